// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage.
// Next-PC source encodings, the reset vector, the nop encoding and a
// sign-extension helper used by the redirect-target logic.
package mips_pkg;

  // Next-PC source, decided by the decoder in the D stage.
  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,  // sequential fetch, PC_F + 4
    NPC_BR  = 2'd1,  // conditional branch, taken only when br_taken is high
    NPC_J   = 2'd2,  // j / jal, pseudo-direct target
    NPC_JR  = 2'd3   // jr / jalr, register target
  } npc_sel_t;

  // Address of the first instruction fetched after reset.
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;

  // sll $0, $0, 0: the architectural nop used to squash fetches.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Sign-extend a 16-bit immediate to 32 bits.
  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/if_stage_npc.sv
// Next-PC computation for the fetch stage (module npc).
// Builds the branch, jump and register targets from the instruction and
// address held in IF/ID, decides whether the current D-stage instruction
// redirects fetch, and selects the next fetch address. All arithmetic
// wraps modulo 2^32.
module npc
  import mips_pkg::*;
(
  input  logic [31:0] pc_f,      // current fetch address
  input  logic [31:0] pc_d,      // address of the instruction in D
  input  logic [25:0] ir_index,  // low 26 bits of the instruction in D
  input  logic [31:0] rs_d,      // forwarded rs value, jr/jalr target
  input  logic [1:0]  npc_sel,   // next-PC source from the decoder
  input  logic        br_taken,  // branch condition, valid for NPC_BR only
  output logic [31:0] next_pc,   // address to load into PC_F
  output logic        redirect   // D-stage control transfer in effect
);

  npc_sel_t    sel;
  logic [31:0] pc_d_plus4;
  logic [31:0] seq_pc;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] target;

  assign sel        = npc_sel_t'(npc_sel);
  assign pc_d_plus4 = pc_d + 32'd4;
  assign seq_pc     = pc_f + 32'd4;

  // Branch offset counts words relative to the delay-slot address.
  assign br_offset  = sext16(ir_index[15:0]) << 2;
  assign br_target  = pc_d_plus4 + br_offset;

  // Pseudo-direct jump: region bits come from the delay-slot address.
  assign j_target   = {pc_d_plus4[31:28], ir_index, 2'b00};

  // Select the redirect target and decide whether it is taken.
  always_comb begin
    target   = seq_pc;
    redirect = 1'b0;
    case (sel)
      NPC_SEQ: begin
        target   = seq_pc;
        redirect = 1'b0;
      end
      NPC_BR: begin
        target   = br_target;
        redirect = br_taken;
      end
      NPC_J: begin
        target   = j_target;
        redirect = 1'b1;
      end
      NPC_JR: begin
        target   = rs_d;
        redirect = 1'b1;
      end
      default: begin
        target   = seq_pc;
        redirect = 1'b0;
      end
    endcase
  end

  // Fall back to sequential fetch unless a control transfer is in effect.
  always_comb begin
    next_pc = seq_pc;
    if (redirect) begin
      next_pc = target;
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register and
// the next-PC sub-module.
// Configuration macro IF_DELAY_SLOT_EN:
//   defined   - architectural delay slot; the instruction after a taken
//               control transfer enters IF/ID normally.
//   undefined - the delay-slot fetch is squashed to a nop on redirect.
// A misaligned fetch address always loads a nop into IF/ID.
module if_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_en,
  input  logic        IR_D_en,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] rs_D,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        misalign_F
);

`ifdef IF_DELAY_SLOT_EN
  localparam bit SQUASH_ON_REDIRECT = 1'b0;
`else
  localparam bit SQUASH_ON_REDIRECT = 1'b1;
`endif

  logic [31:0] pc_f_reg;
  logic [31:0] ir_d_reg;
  logic [31:0] pc_d_reg;
  logic [31:0] pc_f_next;
  logic [31:0] ir_d_next;
  logic        redirect;
  logic        squash;

  npc u_npc (
    .pc_f     (pc_f_reg),
    .pc_d     (pc_d_reg),
    .ir_index (ir_d_reg[25:0]),
    .rs_d     (rs_D),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .next_pc  (pc_f_next),
    .redirect (redirect)
  );

  assign misalign_F = (pc_f_reg[1:0] != 2'b00);

  // A stalled redirect is not squashed: it re-evaluates on the next cycle,
  // so the squash only applies when the PC actually takes the target.
  assign squash = SQUASH_ON_REDIRECT & redirect & PC_en;

  // Choose what enters IF/ID: the fetched word, or a nop when the fetch
  // is misaligned or lies in a squashed delay slot.
  always_comb begin
    ir_d_next = imem_data;
    if (misalign_F || squash) begin
      ir_d_next = NOP_INSTR;
    end
  end

  // PC and IF/ID registers; reset overrides both enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_reg <= RESET_PC;
      ir_d_reg <= NOP_INSTR;
      pc_d_reg <= RESET_PC;
    end else begin
      if (PC_en) begin
        pc_f_reg <= pc_f_next;
      end
      if (IR_D_en) begin
        ir_d_reg <= ir_d_next;
        pc_d_reg <= pc_f_reg;
      end
    end
  end

  assign imem_addr = pc_f_reg;
  assign IR_D      = ir_d_reg;
  assign PC_D      = pc_d_reg;
  assign PC8_D     = pc_d_reg + 32'd8;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage. A table of per-cycle stimulus records
// carries hand-derived expected register contents; each record's
// expectation is queued when its inputs are driven and popped and compared
// after the clock edge. Expectations that depend on IF_DELAY_SLOT_EN
// follow the same macro.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_en;
  logic        IR_D_en;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] rs_D;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] IR_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        misalign_F;

  always #5 clk = ~clk;

  if_stage dut (
    .clk        (clk),
    .reset      (reset),
    .PC_en      (PC_en),
    .IR_D_en    (IR_D_en),
    .npc_sel    (npc_sel),
    .br_taken   (br_taken),
    .rs_D       (rs_D),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .IR_D       (IR_D),
    .PC_D       (PC_D),
    .PC8_D      (PC8_D),
    .misalign_F (misalign_F)
  );

`ifdef IF_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  localparam logic [31:0] BEQ_BACK = 32'h1000_FFFE;  // beq $0,$0,-2
  localparam logic [31:0] J_40     = 32'h0800_0040;  // j index 0x40

  typedef struct {
    logic        rst;
    logic        pc_en;
    logic        ir_en;
    logic [1:0]  sel;
    logic        br;
    logic [31:0] rs;
    logic [31:0] imem;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic [31:0] e_pcd;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] pcd;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Distinctive non-nop instruction word for a given fetch address.
  function automatic logic [31:0] ins(input logic [31:0] a);
    return 32'h2400_0000 | {16'h0000, a[15:0]};
  endfunction

  // Expected IR_D after a redirect: delay slot kept or squashed.
  function automatic logic [31:0] ds_ir(input logic [31:0] w);
    return DS ? w : 32'h0;
  endfunction

  task automatic add(input logic rst, input logic pe, input logic ie,
                     input logic [1:0] sel, input logic br,
                     input logic [31:0] rs, input logic [31:0] imem,
                     input logic [31:0] e_pc, input logic [31:0] e_ir,
                     input logic [31:0] e_pcd);
    vec_t v;
    v.rst = rst; v.pc_en = pe; v.ir_en = ie; v.sel = sel; v.br = br;
    v.rs = rs; v.imem = imem; v.e_pc = e_pc; v.e_ir = e_ir; v.e_pcd = e_pcd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s: got %h, expected %h", idx, nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    reset     = v.rst;
    PC_en     = v.pc_en;
    IR_D_en   = v.ir_en;
    npc_sel   = v.sel;
    br_taken  = v.br;
    rs_D      = v.rs;
    imem_data = v.imem;
    e.pc  = v.e_pc;
    e.ir  = v.e_ir;
    e.pcd = v.e_pcd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL step %0d scoreboard: got empty queue, expected 1 entry", idx);
    end else begin
      e = sb.pop_front();
      chk("imem_addr", idx, imem_addr, e.pc);
      chk("IR_D", idx, IR_D, e.ir);
      chk("PC_D", idx, PC_D, e.pcd);
      chk("PC8_D", idx, PC8_D, e.pcd + 32'd8);
      chk("misalign_F", idx, {31'b0, misalign_F}, {31'b0, (e.pc[1:0] != 2'b00)});
    end
    $display("step %0d: rst=%0b pc_en=%0b ir_en=%0b sel=%0d br=%0b -> pc_f=%h ir_d=%h pc_d=%h mis=%0b",
             idx, v.rst, v.pc_en, v.ir_en, v.sel, v.br, imem_addr, IR_D, PC_D, misalign_F);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t h;
    reset = 1'b1; PC_en = 1'b0; IR_D_en = 1'b0; npc_sel = 2'd0;
    br_taken = 1'b0; rs_D = 32'h0; imem_data = 32'h0;

    // Reset for two cycles (second with enables high), then release.
    add(1,0,0,0,0,32'h0,32'h0,           32'h3000, 32'h0,         32'h3000);
    add(1,1,1,0,0,32'h0,ins(32'h3000),   32'h3000, 32'h0,         32'h3000);
    add(0,1,1,0,0,32'h0,32'h2408_0005,   32'h3004, 32'h2408_0005, 32'h3000);
    add(0,1,1,0,0,32'h0,ins(32'h3004),   32'h3008, ins(32'h3004), 32'h3004);
    add(0,1,1,0,0,32'h0,ins(32'h3008),   32'h300C, ins(32'h3008), 32'h3008);
    add(0,1,1,0,0,32'h0,ins(32'h300C),   32'h3010, ins(32'h300C), 32'h300C);
    // Three-cycle stall at 0x3010; a jump request during stall is ignored.
    add(0,0,0,0,0,32'h0,ins(32'h3010),   32'h3010, ins(32'h300C), 32'h300C);
    add(0,0,0,0,0,32'h0,ins(32'h3010),   32'h3010, ins(32'h300C), 32'h300C);
    add(0,0,0,2,0,32'h0,ins(32'h3010),   32'h3010, ins(32'h300C), 32'h300C);
    add(0,1,1,0,0,32'h0,ins(32'h3010),   32'h3014, ins(32'h3010), 32'h3010);
    // Restart and walk up to a backward beq at 0x3008.
    add(1,0,0,0,0,32'h0,32'h0,           32'h3000, 32'h0,         32'h3000);
    add(0,1,1,0,0,32'h0,ins(32'h3000),   32'h3004, ins(32'h3000), 32'h3000);
    add(0,1,1,0,0,32'h0,ins(32'h3004),   32'h3008, ins(32'h3004), 32'h3004);
    add(0,1,1,0,0,32'h0,BEQ_BACK,        32'h300C, BEQ_BACK,      32'h3008);
    // Taken: 0x3008 + 4 + (-2 << 2) = 0x3004.
    add(0,1,1,1,1,32'h0,ins(32'h300C),   32'h3004, ds_ir(ins(32'h300C)), 32'h300C);
    // Not-taken branch fetches sequentially.
    add(0,1,1,1,0,32'h0,ins(32'h3004),   32'h3008, ins(32'h3004), 32'h3004);
    // jr 0x3100 stalled one cycle, then taken.
    add(0,0,0,3,0,32'h3100,ins(32'h3008), 32'h3008, ins(32'h3004), 32'h3004);
    add(0,1,1,3,0,32'h3100,ins(32'h3008), 32'h3100, ds_ir(ins(32'h3008)), 32'h3008);
    // jr to the top word, sequential wrap to 0, then j index 0x40.
    add(0,1,1,3,0,32'hFFFF_FFFC,ins(32'h3100), 32'hFFFF_FFFC, ds_ir(ins(32'h3100)), 32'h3100);
    add(0,1,1,0,0,32'h0,J_40,            32'h0000_0000, J_40,     32'hFFFF_FFFC);
    add(0,1,1,2,0,32'h0,ins(32'h0),      32'h0000_0100, ds_ir(ins(32'h0)), 32'h0000_0000);
    // jr to a misaligned address; the fetch there becomes a nop.
    add(0,1,1,3,0,32'h3102,ins(32'h100), 32'h3102, ds_ir(ins(32'h100)), 32'h0000_0100);
    add(0,1,1,0,0,32'h0,ins(32'h3102),   32'h3106, 32'h0,         32'h3102);
    // PC advances while IF/ID holds.
    add(0,1,0,0,0,32'h0,ins(32'h3106),   32'h310A, 32'h0,         32'h3102);
    // Reset in the same cycle as a jump, then first fetch from 0x3000.
    add(1,1,1,2,0,32'h0,ins(32'h310A),   32'h3000, 32'h0,         32'h3000);
    add(0,1,1,0,0,32'h0,ins(32'h3000),   32'h3004, ins(32'h3000), 32'h3000);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], i);
    end

    // Hand-written: reset arriving during a stalled jr discards it.
    h.rst = 0; h.pc_en = 0; h.ir_en = 0; h.sel = 2'd3; h.br = 0;
    h.rs = 32'h4000; h.imem = ins(32'h3004);
    h.e_pc = 32'h3004; h.e_ir = ins(32'h3000); h.e_pcd = 32'h3000;
    step(h, 100);
    h.rst = 1;
    h.e_pc = 32'h3000; h.e_ir = 32'h0; h.e_pcd = 32'h3000;
    step(h, 101);
    h.rst = 0; h.pc_en = 1; h.ir_en = 1; h.sel = 2'd0; h.rs = 32'h0;
    h.imem = ins(32'h3000);
    h.e_pc = 32'h3004; h.e_ir = ins(32'h3000); h.e_pcd = 32'h3000;
    step(h, 102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
